mem_port_arbiter: RTL and testbench

//  Shares one memory port between instruction fetch (I) and load/store (D) requesters.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/gnt/rvalid memory port between instruction fetch (I)
// and load/store (D). One transaction in flight, D-priority with an I starvation bound.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stray_rsp
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int TC_W = $clog2(TIMEOUT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0] SC_ONE     = SC_W'(1);
  localparam logic [TC_W-1:0] TMO_LAST   = TC_W'(TIMEOUT - 1);
  localparam logic [TC_W-1:0] TC_ONE     = TC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state_r;
  logic              owner_d_r;
  logic [SC_W-1:0]   starve_cnt_r;
  logic [TC_W-1:0]   tmo_cnt_r;
  logic              grant_d_s;
  logic              grant_i_s;
  logic              wait_done_s;
  logic              rsp_err_s;
  logic [DATA_W-1:0] rsp_data_s;

  // Grant decision: only in IDLE and never while reset is asserted
  always_comb begin
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    if (!reset && (state_r == ST_IDLE)) begin
      if (d_req && ((starve_cnt_r < STARVE_MAX) || !i_req)) begin
        grant_d_s = 1'b1;
      end else begin
        grant_i_s = i_req;
      end
    end else begin
      grant_d_s = 1'b0;
      grant_i_s = 1'b0;
    end
  end

  assign d_gnt = grant_d_s;
  assign i_gnt = grant_i_s;

  // Completion of the WAIT phase: a real response wins over a timeout in the same cycle
  always_comb begin
    wait_done_s = (state_r == ST_WAIT) && (m_rvalid || (tmo_cnt_r == TMO_LAST));
    rsp_err_s   = !m_rvalid;
    rsp_data_s  = (m_rvalid && !m_we) ? m_rdata : {DATA_W{1'b0}};
  end

  // Main FSM with registered memory-side and completion outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      owner_d_r    <= 1'b0;
      starve_cnt_r <= {SC_W{1'b0}};
      tmo_cnt_r    <= {TC_W{1'b0}};
      m_req        <= 1'b0;
      m_we         <= 1'b0;
      m_addr       <= {ADDR_W{1'b0}};
      m_wdata      <= {DATA_W{1'b0}};
      i_rvalid     <= 1'b0;
      i_err        <= 1'b0;
      i_rdata      <= {DATA_W{1'b0}};
      d_rvalid     <= 1'b0;
      d_err        <= 1'b0;
      d_rdata      <= {DATA_W{1'b0}};
      stray_rsp    <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      if (m_rvalid && (state_r != ST_WAIT)) begin
        stray_rsp <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (grant_d_s) begin
            owner_d_r    <= 1'b1;
            m_req        <= 1'b1;
            m_we         <= d_we;
            m_addr       <= d_addr;
            m_wdata      <= d_wdata;
            state_r      <= ST_REQ;
            if (i_req) begin
              starve_cnt_r <= (starve_cnt_r == STARVE_MAX) ? STARVE_MAX : starve_cnt_r + SC_ONE;
            end else begin
              starve_cnt_r <= {SC_W{1'b0}};
            end
          end else if (grant_i_s) begin
            owner_d_r    <= 1'b0;
            m_req        <= 1'b1;
            m_we         <= 1'b0;
            m_addr       <= i_addr;
            m_wdata      <= {DATA_W{1'b0}};
            state_r      <= ST_REQ;
            starve_cnt_r <= {SC_W{1'b0}};
          end
        end
        ST_REQ: begin
          if (m_gnt) begin
            m_req     <= 1'b0;
            tmo_cnt_r <= {TC_W{1'b0}};
            state_r   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_done_s) begin
            if (owner_d_r) begin
              d_rvalid <= 1'b1;
              d_err    <= rsp_err_s;
              d_rdata  <= rsp_data_s;
            end else begin
              i_rvalid <= 1'b1;
              i_err    <= rsp_err_s;
              i_rdata  <= rsp_data_s;
            end
            state_r <= ST_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TC_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          m_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants,
// memory-side requests and the owner/cycle/data/err of every completion.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SL = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_gnt, i_rvalid, i_err;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_gnt, m_rvalid, stray_rsp;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .stray_rsp(stray_rsp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit            is_d;
    logic [DW-1:0] data;
    bit            err;
    int            cyc;
  } rsp_t;
  rsp_t rsp_q[$];

  bit            mon_en = 1'b0;
  logic [DW-1:0] exp_i_rd = '0;
  logic [DW-1:0] exp_d_rd = '0;

  // requesters, knobs and transaction-level model state
  bit            i_pend = 1'b0, d_pend = 1'b0, d_w = 1'b0;
  logic [AW-1:0] i_a = '0, d_a = '0;
  logic [DW-1:0] d_wd = '0;
  bit            rst_val = 1'b1, inj_stray = 1'b0;
  bit            ovr_en = 1'b0;
  int            ovr_k = 0, ovr_j = 0;
  logic [DW-1:0] ovr_data = '0;
  bit            busy = 1'b0, t_d = 1'b0, t_we = 1'b0, exp_stray = 1'b0;
  int            g_cyc = 0, t_k = 0, t_j = 0, free_cyc = 0, sc = 0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wdata = '0, t_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every completion pulse is matched against the head of the scoreboard queue
  always @(negedge clk) begin : mon
    rsp_t e;
    if (mon_en) begin
      if (i_rvalid || d_rvalid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_owner", {62'd0, i_rvalid, d_rvalid}, e.is_d ? 64'd1 : 64'd2);
          chk("rsp_cycle", cyc, e.cyc);
          if (e.is_d) begin
            exp_d_rd = e.data;
            chk("d_err", d_err, e.err);
          end else begin
            exp_i_rd = e.data;
            chk("i_err", i_err, e.err);
          end
        end
      end else if (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
        e = rsp_q.pop_front();
        chk("missing_rvalid", {62'd0, i_rvalid, d_rvalid}, e.is_d ? 64'd1 : 64'd2);
      end
      chk("i_rdata", i_rdata, exp_i_rd);
      chk("d_rdata", d_rdata, exp_d_rd);
      chk("i_err_idle", i_err & ~i_rvalid, 64'd0);
      chk("d_err_idle", d_err & ~d_rvalid, 64'd0);
    end
  end

  // One clock cycle: check registered outputs, drive inputs, check grants, advance model
  task automatic step();
    int   c;
    bit   in_wait, exp_mreq, gd, gi, rsp_now;
    rsp_t e;
    c = cyc;
    if (busy && c >= free_cyc) busy = 1'b0;
    exp_mreq = busy && (c >= g_cyc + 1) && (c <= g_cyc + 1 + t_k);
    in_wait  = busy && (c >= g_cyc + 2 + t_k);
    chk("m_req", m_req, exp_mreq);
    if (exp_mreq) begin
      chk("m_addr", m_addr, t_addr);
      chk("m_we", m_we, t_we);
      if (t_we) chk("m_wdata", m_wdata, t_wdata);
    end
    chk("stray_rsp", stray_rsp, exp_stray);

    reset   = rst_val;
    i_req   = i_pend;
    i_addr  = i_a;
    d_req   = d_pend;
    d_we    = d_w;
    d_addr  = d_a;
    d_wdata = d_wd;
    rsp_now  = busy && (t_j != 0) && (c == g_cyc + 1 + t_k + t_j);
    m_gnt    = busy && (c == g_cyc + 1 + t_k);
    m_rvalid = rsp_now || inj_stray;
    m_rdata  = rsp_now ? t_data : {$urandom, $urandom};
    #1;
    if (m_rvalid && !in_wait) exp_stray = 1'b1;
    if (rst_val) begin
      chk("gnt_in_reset", {62'd0, i_gnt, d_gnt}, 64'd0);
      busy = 1'b0; sc = 0; exp_stray = 1'b0;
      rsp_q.delete();
      exp_i_rd = '0; exp_d_rd = '0;
    end else if (busy) begin
      chk("gnt_while_busy", {62'd0, i_gnt, d_gnt}, 64'd0);
    end else begin
      gd = d_pend && ((sc < SL) || !i_pend);
      gi = !gd && i_pend;
      chk("d_gnt", d_gnt, gd);
      chk("i_gnt", i_gnt, gi);
      if (gd || gi) begin
        if (gd) begin
          t_d = 1'b1; t_we = d_w; t_addr = d_a; t_wdata = d_wd;
          sc = i_pend ? ((sc < SL) ? sc + 1 : sc) : 0;
          d_pend = 1'b0;
        end else begin
          t_d = 1'b0; t_we = 1'b0; t_addr = i_a; t_wdata = '0;
          sc = 0;
          i_pend = 1'b0;
        end
        if (ovr_en) begin
          t_k = ovr_k; t_j = ovr_j; t_data = ovr_data; ovr_en = 1'b0;
        end else begin
          t_k = $urandom_range(0, 3);
          case ($urandom_range(0, 15))
            0:       t_j = 0;
            1:       t_j = TO;
            default: t_j = $urandom_range(1, 4);
          endcase
          t_data = {$urandom, $urandom};
        end
        busy = 1'b1;
        g_cyc = c;
        e.is_d = t_d;
        e.err  = (t_j == 0);
        e.data = ((t_j == 0) || t_we) ? '0 : t_data;
        e.cyc  = c + 2 + t_k + ((t_j == 0) ? TO : t_j);
        free_cyc = e.cyc;
        rsp_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic run_random(input int n, input int pct_i, input int pct_d);
    for (int i = 0; i < n; i++) begin
      if (!i_pend && $urandom_range(0, 99) < pct_i) begin
        i_pend = 1'b1; i_a = {$urandom, $urandom};
      end
      if (!d_pend && $urandom_range(0, 99) < pct_d) begin
        d_pend = 1'b1; d_a = {$urandom, $urandom}; d_w = $urandom_range(0, 1); d_wd = {$urandom, $urandom};
      end
      step();
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && busy; n++) step();
    repeat (2) step();
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    // reset state, with both requesters asking: no grant may appear
    rst_val = 1'b1; i_pend = 1'b1; d_pend = 1'b1; i_a = 64'h1000; d_a = 64'h2000;
    repeat (2) step();
    rst_val = 1'b0; i_pend = 1'b0; d_pend = 1'b0;
    step();
    // minimum-latency fetch
    i_pend = 1'b1; i_a = 64'h40;
    ovr_en = 1'b1; ovr_k = 0; ovr_j = 1; ovr_data = 64'h13;
    repeat (6) step();
    drain();
    // simultaneous requests, D store wins
    i_pend = 1'b1; i_a = 64'h80;
    d_pend = 1'b1; d_w = 1'b1; d_a = 64'h100; d_wd = 64'hDEAD_BEEF;
    ovr_en = 1'b1; ovr_k = 0; ovr_j = 1; ovr_data = 64'h55;
    drain();
    drain();
    // load with no response: timeout completion
    d_pend = 1'b1; d_w = 1'b0; d_a = 64'h300;
    ovr_en = 1'b1; ovr_k = 0; ovr_j = 0; ovr_data = 64'h77;
    drain();
    // m_gnt withheld for three REQ cycles
    d_pend = 1'b1; d_w = 1'b1; d_a = 64'h400; d_wd = 64'h1234_5678;
    ovr_en = 1'b1; ovr_k = 3; ovr_j = 2; ovr_data = 64'h99;
    drain();
    // both requesters saturated: starvation bound
    run_random(300, 100, 100);
    drain();
    run_random(1500, 30, 30);
    i_pend = 1'b0; d_pend = 1'b0;
    drain();
    // reset during WAIT, then a late response arrives
    d_pend = 1'b1; d_w = 1'b0; d_a = 64'h500;
    ovr_en = 1'b1; ovr_k = 0; ovr_j = 0; ovr_data = 64'hAA;
    repeat (4) step();
    rst_val = 1'b1;
    repeat (2) step();
    rst_val = 1'b0;
    repeat (2) step();
    inj_stray = 1'b1;
    step();
    inj_stray = 1'b0;
    repeat (25) step();
    chk("post_reset_m_addr", m_addr, 64'd0);
    chk("post_reset_m_we", m_we, 64'd0);
    chk("post_reset_m_wdata", m_wdata, 64'd0);
    chk("post_reset_stray", stray_rsp, 64'd1);
    chk("rsp_queue_empty", rsp_q.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
